// File: rtl/lc3_isdu_pkg.sv
// Shared types for the LC-3 sequencer: state encoding, control word, opcodes, mux encodings.
package lc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_F1, S_F2, S_F3, S_DEC,
    S_ADD, S_AND, S_NOT,
    S_BR0, S_BR1, S_JMP, S_JSR0, S_JSR1,
    S_L0, S_L1, S_L2,
    S_S0, S_S1, S_S2,
    S_P0, S_P1
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD   = 2'd0;
  localparam logic [1:0] ALUK_AND   = 2'd1;
  localparam logic [1:0] ALUK_NOT   = 2'd2;
  localparam logic [1:0] ALUK_PASSA = 2'd3;

  localparam logic [1:0] PCMUX_INC   = 2'd0;
  localparam logic [1:0] PCMUX_BUS   = 2'd1;
  localparam logic [1:0] PCMUX_ADDER = 2'd2;

  localparam logic [1:0] A2_ZERO  = 2'd0;
  localparam logic [1:0] A2_OFF6  = 2'd1;
  localparam logic [1:0] A2_OFF9  = 2'd2;
  localparam logic [1:0] A2_OFF11 = 2'd3;

  // All fields active-high; a zero word is a safe idle cycle.
  typedef struct packed {
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
    logic [1:0] ADDR2MUX;
    logic [1:0] ALUK;
    logic       MIO_EN, Mem_CE, Mem_OE, Mem_WE;
  } ctrl_t;

  // States that hold the SRAM strobes for the configured wait time.
  function automatic logic is_mem_state(state_t s);
    return (s == S_F2) || (s == S_L1) || (s == S_S2);
  endfunction

endpackage

// File: rtl/lc3_isdu_if.sv
// Sequencer inputs from IR/datapath and the control word / debug state back out.
interface lc3_isdu_if;
  import lc3_pkg::*;

  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;
  ctrl_t      Ctrl;
  state_t     State_Dbg;

  modport master (output Run, Continue, Opcode, IR_5, IR_11, BEN,
                  input  Ctrl, State_Dbg);
  modport slave  (input  Run, Continue, Opcode, IR_5, IR_11, BEN,
                  output Ctrl, State_Dbg);
endinterface

// File: rtl/lc3_isdu.sv
// LC-3 instruction sequencing/decode unit: Moore FSM driving all datapath controls.
module lc3_isdu
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  lc3_isdu_if.slave  bus
);

  localparam logic [1:0] WAIT_LD = 2'(MEM_WAIT);

  state_t     state, state_nxt;
  logic [1:0] wait_cnt;
  logic       wait_done;
  logic       ir5_q, ir11_q;
  ctrl_t      ctrl;

  assign wait_done = (wait_cnt == 2'd0);

  // State, SRAM wait counter, and the IR mode bits captured at decode so the
  // execute-state outputs depend on registers only.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_HALTED;
      wait_cnt <= 2'd0;
      ir5_q    <= 1'b0;
      ir11_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (is_mem_state(state_nxt) && (state_nxt != state))
        wait_cnt <= WAIT_LD;
      else if (is_mem_state(state) && !wait_done)
        wait_cnt <= wait_cnt - 2'd1;
      if (state == S_DEC) begin
        ir5_q  <= bus.IR_5;
        ir11_q <= bus.IR_11;
      end
    end
  end

  // Next-state: fetch/decode, opcode dispatch, memory waits, pause handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_HALTED: if (bus.Run) state_nxt = S_F1;
      S_F1:     state_nxt = S_F2;
      S_F2:     if (wait_done) state_nxt = S_F3;
      S_F3:     state_nxt = S_DEC;
      S_DEC: begin
        case (bus.Opcode)
          OP_ADD:  state_nxt = S_ADD;
          OP_AND:  state_nxt = S_AND;
          OP_NOT:  state_nxt = S_NOT;
          OP_BR:   state_nxt = S_BR0;
          OP_JMP:  state_nxt = S_JMP;
          OP_JSR:  state_nxt = S_JSR0;
          OP_LDR:  state_nxt = S_L0;
          OP_STR:  state_nxt = S_S0;
          OP_PSE:  state_nxt = S_P0;
          default: state_nxt = S_F1;
        endcase
      end
      S_ADD, S_AND, S_NOT, S_BR1, S_JMP, S_JSR1, S_L2: state_nxt = S_F1;
      S_BR0:    state_nxt = bus.BEN ? S_BR1 : S_F1;
      S_JSR0:   state_nxt = S_JSR1;
      S_L0:     state_nxt = S_L1;
      S_L1:     if (wait_done) state_nxt = S_L2;
      S_S0:     state_nxt = S_S1;
      S_S1:     state_nxt = S_S2;
      S_S2:     if (wait_done) state_nxt = S_F1;
      S_P0:     if (bus.Continue) state_nxt = S_P1;
      S_P1:     if (!bus.Continue) state_nxt = S_F1;
      default:  state_nxt = S_HALTED;
    endcase
  end

  // Control word decode from state (plus captured IR bits / wait counter).
  always_comb begin
    ctrl = '0;
    unique case (state)
      S_F1: begin
        ctrl.GatePC = 1'b1; ctrl.LD_MAR = 1'b1; ctrl.LD_PC = 1'b1; ctrl.PCMUX = PCMUX_INC;
      end
      S_F2, S_L1: begin
        ctrl.Mem_CE = 1'b1; ctrl.Mem_OE = 1'b1; ctrl.MIO_EN = 1'b1;
        ctrl.LD_MDR = wait_done;
      end
      S_F3:  begin ctrl.GateMDR = 1'b1; ctrl.LD_IR = 1'b1; end
      S_DEC: ctrl.LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        ctrl.GateALU = 1'b1; ctrl.LD_REG = 1'b1; ctrl.LD_CC = 1'b1; ctrl.SR1MUX = 1'b1;
        ctrl.ALUK    = (state == S_ADD) ? ALUK_ADD : (state == S_AND) ? ALUK_AND : ALUK_NOT;
        ctrl.SR2MUX  = (state != S_NOT) & ir5_q;
      end
      S_BR1: begin
        ctrl.LD_PC = 1'b1; ctrl.PCMUX = PCMUX_ADDER; ctrl.ADDR2MUX = A2_OFF9;
      end
      S_JMP: begin
        ctrl.LD_PC = 1'b1; ctrl.PCMUX = PCMUX_ADDER; ctrl.ADDR1MUX = 1'b1;
        ctrl.SR1MUX = 1'b1; ctrl.ADDR2MUX = A2_ZERO;
      end
      S_JSR0: begin ctrl.GatePC = 1'b1; ctrl.DRMUX = 1'b1; ctrl.LD_REG = 1'b1; end
      S_JSR1: begin
        // JSR: PC + off11; JSRR: BaseR + 0.
        ctrl.LD_PC    = 1'b1; ctrl.PCMUX = PCMUX_ADDER;
        ctrl.ADDR1MUX = !ir11_q;
        ctrl.SR1MUX   = !ir11_q;
        ctrl.ADDR2MUX = ir11_q ? A2_OFF11 : A2_ZERO;
      end
      S_L0, S_S0: begin
        ctrl.ADDR1MUX = 1'b1; ctrl.SR1MUX = 1'b1; ctrl.ADDR2MUX = A2_OFF6;
        ctrl.GateMARMUX = 1'b1; ctrl.LD_MAR = 1'b1;
      end
      S_L2: begin ctrl.GateMDR = 1'b1; ctrl.LD_REG = 1'b1; ctrl.LD_CC = 1'b1; end
      S_S1: begin
        ctrl.SR1MUX = 1'b0; ctrl.ALUK = ALUK_PASSA; ctrl.GateALU = 1'b1; ctrl.LD_MDR = 1'b1;
      end
      S_S2: begin ctrl.Mem_CE = 1'b1; ctrl.Mem_WE = 1'b1; end
      S_P0: ctrl.LD_LED = 1'b1;
      default: ctrl = '0;
    endcase
  end

  assign bus.Ctrl      = ctrl;
  assign bus.State_Dbg = state;

endmodule

// File: tb/tb_lc3_isdu.sv
// Scoreboard bench: three sequencers (MEM_WAIT 1/0/3) run directed then random
// instructions; a reference model expands each instruction into per-cycle
// expected state/control words, and a monitor compares them every cycle.
module tb_lc3_isdu;
  import lc3_pkg::*;

  typedef struct { state_t st; ctrl_t c; logic cont; } exp_t;
  typedef exp_t seq_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s[3], run_s[3], cont_s[3], ir5_s[3], ir11_s[3], ben_s[3];
  logic [3:0] op_s[3];
  state_t     st_s[3];
  ctrl_t      ctl_s[3];
  exp_t       q[3][$];
  int         n_pass = 0;
  int         n_tot  = 0;

  for (genvar g = 0; g < 3; g++) begin : gi
    lc3_isdu_if bus();
    assign bus.Run      = run_s[g];
    assign bus.Continue = cont_s[g];
    assign bus.Opcode   = op_s[g];
    assign bus.IR_5     = ir5_s[g];
    assign bus.IR_11    = ir11_s[g];
    assign bus.BEN      = ben_s[g];
    assign st_s[g]      = bus.State_Dbg;
    assign ctl_s[g]     = bus.Ctrl;
    lc3_isdu #(.MEM_WAIT((g == 0) ? 1 : (g == 1) ? 0 : 3)) dut (
      .Clk(clk), .Reset(rst_s[g]), .bus(bus.slave));
  end

  task automatic cmp(string nm, logic [31:0] got, logic [31:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, want);
  endtask

  function automatic exp_t mk(state_t st, ctrl_t c, logic ct);
    exp_t e;
    e.st = st; e.c = c; e.cont = ct;
    return e;
  endfunction

  function automatic ctrl_t f1_w();
    ctrl_t c = '0;
    c.GatePC = 1; c.LD_MAR = 1; c.LD_PC = 1; c.PCMUX = 2'd0;
    return c;
  endfunction

  function automatic ctrl_t rd_w(logic last);
    ctrl_t c = '0;
    c.Mem_CE = 1; c.Mem_OE = 1; c.MIO_EN = 1; c.LD_MDR = last;
    return c;
  endfunction

  // Reference: one instruction as a list of cycles. Memory phases last w+1
  // cycles; pause sits k cycles in P0 then sees a 3-cycle Continue pulse.
  function automatic seq_t build(int w, logic [3:0] op, logic i5, logic i11, logic bn, int k);
    seq_t s;
    ctrl_t c;
    s.push_back(mk(S_F1, f1_w(), 1'b0));
    for (int i = 0; i <= w; i++) s.push_back(mk(S_F2, rd_w(i == w), 1'b0));
    c = '0; c.GateMDR = 1; c.LD_IR = 1; s.push_back(mk(S_F3, c, 1'b0));
    c = '0; c.LD_BEN = 1; s.push_back(mk(S_DEC, c, (op == 4'hD) && (k == 1)));
    case (op)
      4'h1, 4'h5, 4'h9: begin
        c = '0; c.GateALU = 1; c.LD_REG = 1; c.LD_CC = 1; c.SR1MUX = 1;
        c.ALUK   = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd2;
        c.SR2MUX = (op != 4'h9) && i5;
        s.push_back(mk((op == 4'h1) ? S_ADD : (op == 4'h5) ? S_AND : S_NOT, c, 1'b0));
      end
      4'h0: begin
        s.push_back(mk(S_BR0, '0, 1'b0));
        if (bn) begin
          c = '0; c.LD_PC = 1; c.PCMUX = 2'd2; c.ADDR2MUX = 2'd2;
          s.push_back(mk(S_BR1, c, 1'b0));
        end
      end
      4'hC: begin
        c = '0; c.LD_PC = 1; c.PCMUX = 2'd2; c.ADDR1MUX = 1; c.SR1MUX = 1;
        s.push_back(mk(S_JMP, c, 1'b0));
      end
      4'h4: begin
        c = '0; c.GatePC = 1; c.DRMUX = 1; c.LD_REG = 1;
        s.push_back(mk(S_JSR0, c, 1'b0));
        c = '0; c.LD_PC = 1; c.PCMUX = 2'd2;
        if (i11) c.ADDR2MUX = 2'd3;
        else begin c.ADDR1MUX = 1; c.SR1MUX = 1; end
        s.push_back(mk(S_JSR1, c, 1'b0));
      end
      4'h6, 4'h7: begin
        c = '0; c.ADDR1MUX = 1; c.SR1MUX = 1; c.ADDR2MUX = 2'd1; c.GateMARMUX = 1; c.LD_MAR = 1;
        s.push_back(mk((op == 4'h6) ? S_L0 : S_S0, c, 1'b0));
        if (op == 4'h6) begin
          for (int i = 0; i <= w; i++) s.push_back(mk(S_L1, rd_w(i == w), 1'b0));
          c = '0; c.GateMDR = 1; c.LD_REG = 1; c.LD_CC = 1;
          s.push_back(mk(S_L2, c, 1'b0));
        end else begin
          c = '0; c.ALUK = 2'd3; c.GateALU = 1; c.LD_MDR = 1;
          s.push_back(mk(S_S1, c, 1'b0));
          c = '0; c.Mem_CE = 1; c.Mem_WE = 1;
          for (int i = 0; i <= w; i++) s.push_back(mk(S_S2, c, 1'b0));
        end
      end
      4'hD: begin
        c = '0; c.LD_LED = 1;
        for (int i = 0; i < k; i++) s.push_back(mk(S_P0, c, i == k - 1));
        s.push_back(mk(S_P1, '0, 1'b1));
        s.push_back(mk(S_P1, '0, 1'b1));
        s.push_back(mk(S_P1, '0, 1'b0));
      end
      default: ;
    endcase
    return s;
  endfunction

  task automatic drive(int g, int w);
    seq_t seq;
    logic [3:0] op;
    logic i5, i11, bn;
    int k;
    logic [3:0] dop[14] = '{4'h1, 4'h0, 4'h0, 4'h4, 4'h4, 4'h7, 4'h6, 4'hD, 4'hD, 4'hC, 4'h5, 4'h9, 4'h3, 4'h1};
    logic [2:0] dfl[14] = '{3'b100, 3'b000, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000,
                            3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
    int dk[14] = '{1, 1, 1, 1, 1, 1, 1, 20, 1, 1, 1, 1, 1, 1};
    rst_s[g] = 1; run_s[g] = 0; cont_s[g] = 0; op_s[g] = '0;
    ir5_s[g] = 0; ir11_s[g] = 0; ben_s[g] = 0;
    repeat (2) @(posedge clk);
    #1;
    cmp($sformatf("u%0d reset state", g), 32'(st_s[g]), 32'(S_HALTED));
    cmp($sformatf("u%0d reset ctrl", g), 32'(ctl_s[g]), 32'd0);
    @(negedge clk) rst_s[g] = 0;
    @(posedge clk); #1;
    cmp($sformatf("u%0d halted without Run", g), 32'(st_s[g]), 32'(S_HALTED));
    @(negedge clk);
    run_s[g] = 1;
    q[g].push_back(mk(S_F1, f1_w(), 1'b0));
    q[g].push_back(mk(S_F2, rd_w(w == 0), 1'b0));
    @(posedge clk); @(posedge clk); #3;
    rst_s[g] = 1; #1;
    cmp($sformatf("u%0d async reset mid-F2 state", g), 32'(st_s[g]), 32'(S_HALTED));
    cmp($sformatf("u%0d async reset mid-F2 ctrl", g), 32'(ctl_s[g]), 32'd0);
    @(negedge clk) rst_s[g] = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 14) begin
        op = dop[i]; {i5, i11, bn} = dfl[i]; k = dk[i];
      end else begin
        op  = 4'($urandom_range(0, 15));
        i5  = 1'($urandom_range(0, 1));
        i11 = 1'($urandom_range(0, 1));
        bn  = 1'($urandom_range(0, 1));
        k   = $urandom_range(1, 6);
      end
      seq = build(w, op, i5, i11, bn, k);
      foreach (seq[j]) q[g].push_back(seq[j]);
      for (int c = 0; c < seq.size(); c++) begin
        @(posedge clk);
        @(negedge clk);
        if (c == 0) begin
          op_s[g] = op; ir5_s[g] = i5; ir11_s[g] = i11; ben_s[g] = bn;
        end
        cont_s[g] = seq[c].cont;
      end
    end
  endtask

  // Monitor: each unit presents one control word per cycle.
  exp_t e;
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 3; g++) begin
      if (q[g].size() > 0) begin
        e = q[g].pop_front();
        cmp($sformatf("u%0d state", g), 32'(st_s[g]), 32'(e.st));
        cmp($sformatf("u%0d ctrl in %s", g, e.st.name()), 32'(ctl_s[g]), 32'(e.c));
        cmp($sformatf("u%0d single bus gate", g),
            32'($countones({ctl_s[g].GatePC, ctl_s[g].GateMDR,
                            ctl_s[g].GateALU, ctl_s[g].GateMARMUX}) <= 1), 32'd1);
      end
    end
  end

  initial begin
    fork
      drive(0, 1);
      drive(1, 0);
      drive(2, 3);
    join
    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < 3; g++)
      cmp($sformatf("u%0d scoreboard drained", g), 32'(q[g].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (%0d/%0d)", n_pass, n_tot);
    $fatal(1);
  end

endmodule

// File: doc/lc3_isdu.md
# lc3_isdu

Instruction sequencing and decode unit for the LC-3 datapath: a Moore state machine that fetches, decodes and executes one instruction at a time and drives every datapath control line. That includes the register-file write enable, destination select and SR1 select. It sits directly upstream of the register file, the ALU and the PC/MAR/MDR/IR registers, and drives the SRAM strobes.

## Interface
Parameters:
- `MEM_WAIT`, default 1: extra cycles the SRAM read/write strobe is held before the data is used; legal range 0–3.

Ports:
- `Clk`, input, 1: rising-edge clock.
- `Reset`, input, 1: asynchronous, active-high. The state register clears immediately on assertion.
- `Run`, input, 1: start execution from Halted.
- `Continue`, input, 1: resume from PAUSE; a full press and release is required.
- `Opcode`, input, 4: IR[15:12].
- `IR_5`, input, 1: immediate-mode bit for ADD/AND.
- `IR_11`, input, 1: JSR (1) versus JSRR (0).
- `BEN`, input, 1: registered branch-enable from the datapath.
- `Ctrl`, output, `ctrl_t`: packed control word; all fields are active-high.
- `State_Dbg`, output, `state_t`: current state, for hex display and bench.

## Operation
- Outputs are purely a function of the state register (Moore); there is no combinational input-to-output path. Every `Ctrl` field defaults to 0 in every state unless listed below.
- `ctrl_t` fields:
  - register loads: `LD_MAR`, `LD_MDR`, `LD_IR`, `LD_BEN`, `LD_CC`, `LD_REG`, `LD_PC`, `LD_LED`
  - bus gates: `GatePC`, `GateMDR`, `GateALU`, `GateMARMUX`
  - mux selects:
    - `PCMUX[1:0]` (0 PC+1, 1 bus, 2 adder)
    - `DRMUX` (0 IR[11:9], 1 R7)
    - `SR1MUX` (0 IR[11:9], 1 IR[8:6])
    - `SR2MUX` (= `IR_5`)
    - `ADDR1MUX` (0 PC, 1 SR1)
    - `ADDR2MUX[1:0]` (0 zero, 1 off6, 2 off9, 3 off11)
    - `ALUK[1:0]` (0 ADD, 1 AND, 2 NOT, 3 PASSA)
  - memory: `MIO_EN` (MDR loads from memory), `Mem_CE`, `Mem_OE`, `Mem_WE`
- State sequence:
  - Reset → Halted. Halted → F1 when `Run`=1.
  - F1: `GatePC`, `LD_MAR`, `LD_PC`, `PCMUX`=0.
  - F2: `Mem_CE`, `Mem_OE`, `MIO_EN`; held `MEM_WAIT`+1 cycles with an internal wait counter. `LD_MDR` is asserted on the last cycle only.
  - F3: `GateMDR`, `LD_IR`.
  - DEC: `LD_BEN`; branch on `Opcode`.
- Execute states, each returning to F1 unless noted:
  - ADD/AND/NOT (0001/0101/1001): one state with `GateALU`, `LD_REG`, `LD_CC`, `SR1MUX`=1, and the matching `ALUK`.
  - BR (0000): BR0 tests `BEN`; if 0 → F1, if 1 → BR1 (`PCMUX`=2, `ADDR2MUX`=2, `LD_PC`).
  - JMP (1100): `ADDR1MUX`=1, `SR1MUX`=1, `ADDR2MUX`=0, `PCMUX`=2, `LD_PC`.
  - JSR (0100): JSR0 (`GatePC`, `DRMUX`=1, `LD_REG`) → JSR1. JSR1 uses `IR_11` to select between PC+off11 and BaseR; `LD_PC`.
  - LDR (0110):
    - L0: `ADDR1MUX`=1, `SR1MUX`=1, `ADDR2MUX`=1, `GateMARMUX`, `LD_MAR`.
    - L1: memory read, identical to F2.
    - L2: `GateMDR`, `LD_REG`, `LD_CC`.
  - STR (0111):
    - S0: same as L0.
    - S1: `SR1MUX`=0, `ALUK`=3, `GateALU`, `LD_MDR`, `MIO_EN`=0.
    - S2: `Mem_CE`, `Mem_WE`, held `MEM_WAIT`+1 cycles.
  - PAUSE (1101):
    - P0: `LD_LED`; waits while `Continue`=0.
    - P1: waits while `Continue`=1, then → F1.
  - Any other opcode: DEC → F1, with no architectural side effect.
- Only one of the four Gate signals is ever high in a given state; the bench asserts this.

## Timing
- Reset value: state Halted, wait counter 0, every `Ctrl` field 0.
- `Reset` asserted mid-write drops `Mem_WE` asynchronously.
- Clock counts with `MEM_WAIT`=1:
  - fetch plus DEC: 5 cycles.
  - ADD/AND/NOT: 6 cycles.
  - BR: 6 cycles not taken, 7 taken.
  - JMP: 6 cycles.
  - JSR: 7 cycles.
  - LDR: 9 cycles.
  - STR: 9 cycles.
- With `MEM_WAIT`=0, fetch is 4 cycles.
- `LD_REG` is high for exactly one cycle per register-writing instruction. The register file captures on that edge.
- `BEN` is sampled in BR0, one cycle after DEC loads it.
- `Run` held high in Halted starts F1 on the next edge. `Run` is ignored in all other states.
- `Continue` held high entering P0 advances immediately to P1, then waits for release.
- The wait counter reloads on every entry to F2, L1 or S2 and never wraps.

## Structure
- Package `lc3_pkg` holds:
  - `state_t` enum, `ctrl_t` packed struct;
  - opcode localparams (`OP_ADD`, ...);
  - `ALUK`, `PCMUX` and `ADDR2MUX` encodings.
- Single module, split into a state register `always_ff`, a next-state `always_comb` and an output `always_comb` with defaults at the top. No sub-module.

## Test plan
- Reset mid-F2 with `Mem_OE` high → outputs go to 0 before the next edge; state reads Halted. `Run`=1 → F1 on the next edge.
- Opcode 0001, `IR_5`=1 → `LD_REG` is high exactly at cycle 6, with `SR2MUX`=1, `ALUK`=0 and `LD_CC`=1; state returns to F1 at cycle 7.
- Opcode 0000 with `BEN`=0 → no `LD_PC` after F1. With `BEN`=1 → `LD_PC`=1 and `PCMUX`=2 in cycle 7.
- Opcode 0100, `IR_11`=1 → JSR0 drives `DRMUX`=1 and `LD_REG`; JSR1 drives `ADDR2MUX`=3 and `LD_PC`.
- Opcode 0111 → `Mem_WE` high for exactly `MEM_WAIT`+1 cycles, after S1 drives `ALUK`=3 and `LD_MDR`. Repeat with `MEM_WAIT`=0 and `MEM_WAIT`=3.
- Opcode 1101 → stays in P0 for 20 cycles with `Continue`=0. `Continue` pulse of 3 cycles → P1, then F1 one cycle after release.
